tlb_unit: RTL and testbench

//  32-entry, fully associative, joint MIPS32 TLB. Serves CP0's TLB commands: TLBR, TLBWI, TLBWR, TLBP.

---
 rtl/tlb_unit_pkg.sv | 74 +++++++
 rtl/tlb_match.sv | 37 +++
 rtl/tlb_unit.sv | 131 +++++++++++++
 tb/tb_tlb_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_unit_pkg.sv
// Shared types and helpers for the joint MIPS32 TLB: entry layout, lookup results,
// field packing for CP0 EntryLo, and the translation/fault rules.
package tlb_unit_pkg;

  localparam int TLB_ENTRIES = 32;
  localparam int TLB_IDXBITS = 5;

  localparam logic [2:0]  CATTR_UNCACHED = 3'd2;
  localparam logic [31:0] PROBE_MISS     = 32'h8000_0000;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_pair_t;

  typedef struct packed {
    logic [18:0]     vpn2;
    logic [7:0]      asid;
    logic            g;
    logic [11:0]     mask;
    tlb_pair_t [1:0] pair;
  } tlb_entry_t;

  typedef struct packed {
    logic                   hit;
    logic [TLB_IDXBITS-1:0] idx;
    tlb_pair_t              sel;
    logic [31:0]            paddr;
  } tlb_result_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  cattr;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlate_t;

  function automatic logic [3:0] popcount12(input logic [11:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

  function automatic tlb_pair_t lo_to_pair(input logic [31:0] lo);
    return '{pfn: lo[25:6], c: lo[5:3], d: lo[2], v: lo[1]};
  endfunction

  function automatic logic [31:0] pair_to_lo(input tlb_pair_t p, input logic g);
    return {6'b0, p, g};
  endfunction

  // kseg0/kseg1 bypass the TLB entirely; everything else takes the matched entry.
  function automatic xlate_t translate(input logic [31:0] va, input logic store,
                                       input logic [2:0] k0, input tlb_result_t r);
    xlate_t x;
    x = '0;
    if (va[31:30] == 2'b10) begin
      x.paddr = {3'b000, va[28:0]};
      x.cattr = va[29] ? CATTR_UNCACHED : k0;
    end else begin
      x.paddr    = r.paddr;
      x.cattr    = r.sel.c;
      x.refill   = !r.hit;
      x.invalid  = r.hit && !r.sel.v;
      x.modified = store && r.hit && r.sel.v && !r.sel.d;
    end
    return x;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational associative lookup: lowest matching index wins, then the odd/even
// pair is chosen and the physical frame merged with the page-offset bits under mask.
module tlb_match
  import tlb_unit_pkg::*;
(
  input  tlb_entry_t  entries [TLB_ENTRIES],
  input  logic [31:0] va,
  input  logic [7:0]  asid,
  output tlb_result_t result
);

  tlb_entry_t e;
  tlb_pair_t  p;
  logic [4:0] odd_pos;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    // Descending scan so the last assignment is the lowest matching index.
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if ((((entries[i].vpn2 ^ va[31:13]) & ~{7'b0, entries[i].mask}) == '0) &&
          (entries[i].g || (entries[i].asid == asid))) begin
        result.hit = 1'b1;
        result.idx = i[TLB_IDXBITS-1:0];
      end
    end
    e       = entries[result.idx];
    odd_pos = 5'd12 + {1'b0, popcount12(e.mask)};
    p       = e.pair[va[odd_pos]];
    result.sel   = p;
    result.paddr = {p.pfn, va[11:0]};
    for (int b = 0; b < 12; b++) begin
      if (e.mask[b]) result.paddr[12+b] = va[12+b];
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// 32-entry fully associative joint TLB serving CP0 TLBR/TLBWI/TLBWR/TLBP and
// translating fetch and data addresses with one-cycle registered results.
module tlb_unit
  import tlb_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tlbr_req,
  input  logic        tlbwi_req,
  input  logic        tlbwr_req,
  input  logic        tlbp_req,
  input  logic [31:0] index,
  input  logic [31:0] random,
  input  logic [31:0] entryhi,
  input  logic [31:0] entrylo0,
  input  logic [31:0] entrylo1,
  input  logic [11:0] mask,
  input  logic [2:0]  config_k0,
  output logic        tlbr_done,
  output logic [31:0] tlbr_lo0,
  output logic [31:0] tlbr_lo1,
  output logic [31:0] tlbr_hi,
  output logic [11:0] tlbr_mask,
  output logic        tlbp_done,
  output logic [31:0] tlbp_index,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        d_store,
  output logic        i_valid,
  output logic        d_valid,
  output logic [31:0] i_paddr,
  output logic [31:0] d_paddr,
  output logic [2:0]  i_cattr,
  output logic [2:0]  d_cattr,
  output logic        i_refill,
  output logic        d_refill,
  output logic        i_invalid,
  output logic        d_invalid,
  output logic        d_modified
);

  tlb_entry_t             entries [TLB_ENTRIES];
  tlb_entry_t             wr_entry;
  tlb_entry_t             rd_entry;
  logic [TLB_IDXBITS-1:0] wr_idx;
  logic [TLB_IDXBITS-1:0] rd_idx;
  tlb_result_t            i_res, d_res, probe_res;
  xlate_t                 i_q, d_q;
  logic                   unused_bits;

  always_comb begin
    wr_entry.vpn2    = entryhi[31:13];
    wr_entry.asid    = entryhi[7:0];
    wr_entry.g       = entrylo0[0] & entrylo1[0];
    wr_entry.mask    = mask;
    wr_entry.pair[0] = lo_to_pair(entrylo0);
    wr_entry.pair[1] = lo_to_pair(entrylo1);
  end

  assign wr_idx   = tlbwi_req ? index[TLB_IDXBITS-1:0] : random[TLB_IDXBITS-1:0];
  assign rd_idx   = index[TLB_IDXBITS-1:0];
  assign rd_entry = entries[rd_idx];

  // NOTE: only the valid bits are reset; tags and frames are storage and keep their contents.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        entries[i].pair[0].v <= 1'b0;
        entries[i].pair[1].v <= 1'b0;
      end
    end else if (tlbwi_req || tlbwr_req) begin
      entries[wr_idx] <= wr_entry;
    end
  end

  tlb_match u_match_i (.entries(entries), .va(i_vaddr), .asid(entryhi[7:0]), .result(i_res));
  tlb_match u_match_d (.entries(entries), .va(d_vaddr), .asid(entryhi[7:0]), .result(d_res));
  tlb_match u_match_p (.entries(entries), .va({entryhi[31:13], 13'b0}),
                       .asid(entryhi[7:0]), .result(probe_res));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_q     <= '0;
      d_q     <= '0;
    end else begin
      i_valid <= i_req;
      d_valid <= d_req;
      if (i_req) i_q <= translate(i_vaddr, 1'b0, config_k0, i_res);
      if (d_req) d_q <= translate(d_vaddr, d_store, config_k0, d_res);
    end
  end

  assign i_paddr    = i_q.paddr;
  assign i_cattr    = i_q.cattr;
  assign i_refill   = i_q.refill;
  assign i_invalid  = i_q.invalid;
  assign d_paddr    = d_q.paddr;
  assign d_cattr    = d_q.cattr;
  assign d_refill   = d_q.refill;
  assign d_invalid  = d_q.invalid;
  assign d_modified = d_q.modified;

  // Read and probe sample the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tlbr_done <= 1'b0;
      tlbp_done <= 1'b0;
    end else begin
      tlbr_done <= tlbr_req;
      tlbp_done <= tlbp_req;
      if (tlbr_req) begin
        tlbr_lo0  <= pair_to_lo(rd_entry.pair[0], rd_entry.g);
        tlbr_lo1  <= pair_to_lo(rd_entry.pair[1], rd_entry.g);
        tlbr_hi   <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
        tlbr_mask <= rd_entry.mask;
      end
      if (tlbp_req)
        tlbp_index <= probe_res.hit ? {{(32-TLB_IDXBITS){1'b0}}, probe_res.idx} : PROBE_MISS;
    end
  end

  assign unused_bits = ^{index[31:TLB_IDXBITS], random[31:TLB_IDXBITS], entryhi[12:8],
                         entrylo0[31:26], entrylo1[31:26], i_q.modified,
                         probe_res.sel, probe_res.paddr};

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed scenarios followed by randomized traffic,
// all compared against an array-based model of the TLB rules.
module tb_tlb_unit;

  logic        clk, resetn;
  logic        tlbr_req, tlbwi_req, tlbwr_req, tlbp_req;
  logic [31:0] index, random, entryhi, entrylo0, entrylo1;
  logic [11:0] mask;
  logic [2:0]  config_k0;
  logic        tlbr_done, tlbp_done;
  logic [31:0] tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
  logic [11:0] tlbr_mask;
  logic        i_req, d_req, d_store;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_valid, d_valid;
  logic [31:0] i_paddr, d_paddr;
  logic [2:0]  i_cattr, d_cattr;
  logic        i_refill, d_refill, i_invalid, d_invalid, d_modified;

  int n_cmp = 0;
  int n_bad = 0;

  tlb_unit dut (
    .clk(clk), .resetn(resetn),
    .tlbr_req(tlbr_req), .tlbwi_req(tlbwi_req), .tlbwr_req(tlbwr_req), .tlbp_req(tlbp_req),
    .index(index), .random(random), .entryhi(entryhi), .entrylo0(entrylo0),
    .entrylo1(entrylo1), .mask(mask), .config_k0(config_k0),
    .tlbr_done(tlbr_done), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1), .tlbr_hi(tlbr_hi),
    .tlbr_mask(tlbr_mask), .tlbp_done(tlbp_done), .tlbp_index(tlbp_index),
    .i_req(i_req), .i_vaddr(i_vaddr), .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store),
    .i_valid(i_valid), .d_valid(d_valid), .i_paddr(i_paddr), .d_paddr(d_paddr),
    .i_cattr(i_cattr), .d_cattr(d_cattr), .i_refill(i_refill), .d_refill(d_refill),
    .i_invalid(i_invalid), .d_invalid(d_invalid), .d_modified(d_modified)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one slot per entry, fields as CP0 sees them.
  bit [18:0] m_vpn2 [32];
  bit [7:0]  m_asid [32];
  bit        m_g    [32];
  bit [11:0] m_mask [32];
  bit [19:0] m_pfn  [32][2];
  bit [2:0]  m_c    [32][2];
  bit        m_d    [32][2];
  bit        m_v    [32][2];

  typedef struct packed {
    bit [31:0] paddr;
    bit [2:0]  cattr;
    bit        refill;
    bit        invalid;
    bit        modified;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int probe_model(input bit [18:0] vpn, input bit [7:0] asid);
    bit [18:0] care;
    for (int i = 0; i < 32; i++) begin
      care = ~{7'b0, m_mask[i]};
      if ((((m_vpn2[i] ^ vpn) & care) == 0) && (m_g[i] || m_asid[i] == asid)) return i;
    end
    return -1;
  endfunction

  function automatic exp_t lookup_model(input bit [31:0] va, input bit store,
                                        input bit [7:0] asid, input bit [2:0] k0);
    exp_t e;
    int idx, sh;
    bit odd;
    bit [19:0] frame;
    e = '0;
    if (va[31:30] == 2'b10) begin
      e.paddr = va & 32'h1FFF_FFFF;
      e.cattr = va[29] ? 3'd2 : k0;
      return e;
    end
    idx = probe_model(va[31:13], asid);
    if (idx < 0) begin
      e.refill = 1'b1;
      return e;
    end
    sh    = 12 + $countones(m_mask[idx]);
    odd   = va[sh];
    frame = m_pfn[idx][odd];
    for (int i = 0; i < 12; i++) if (m_mask[idx][i]) frame[i] = va[12+i];
    e.paddr    = {frame, va[11:0]};
    e.cattr    = m_c[idx][odd];
    e.invalid  = !m_v[idx][odd];
    e.modified = store && m_v[idx][odd] && !m_d[idx][odd];
    return e;
  endfunction

  task automatic write_model(input int w);
    m_vpn2[w] = entryhi[31:13];
    m_asid[w] = entryhi[7:0];
    m_g[w]    = entrylo0[0] & entrylo1[0];
    m_mask[w] = mask;
    m_pfn[w][0] = entrylo0[25:6]; m_c[w][0] = entrylo0[5:3];
    m_d[w][0]   = entrylo0[2];    m_v[w][0] = entrylo0[1];
    m_pfn[w][1] = entrylo1[25:6]; m_c[w][1] = entrylo1[5:3];
    m_d[w][1]   = entrylo1[2];    m_v[w][1] = entrylo1[1];
  endtask

  task automatic clear_reqs();
    tlbr_req = 0; tlbwi_req = 0; tlbwr_req = 0; tlbp_req = 0;
    i_req = 0; d_req = 0; d_store = 0;
  endtask

  // One clock: predict from pre-edge model state, update the model at the edge, compare after it.
  task automatic tick();
    exp_t ei, ed;
    int pidx, ri;
    bit rst, ireq, dreq, rreq, preq;
    bit [31:0] r_lo0, r_lo1, r_hi;
    bit [11:0] r_mask;
    rst  = !resetn;
    ireq = i_req; dreq = d_req; rreq = tlbr_req; preq = tlbp_req;
    ei   = lookup_model(i_vaddr, 1'b0, entryhi[7:0], config_k0);
    ed   = lookup_model(d_vaddr, d_store, entryhi[7:0], config_k0);
    ri   = int'(index % 32);
    r_lo0  = {6'b0, m_pfn[ri][0], m_c[ri][0], m_d[ri][0], m_v[ri][0], m_g[ri]};
    r_lo1  = {6'b0, m_pfn[ri][1], m_c[ri][1], m_d[ri][1], m_v[ri][1], m_g[ri]};
    r_hi   = {m_vpn2[ri], 5'b0, m_asid[ri]};
    r_mask = m_mask[ri];
    pidx = probe_model(entryhi[31:13], entryhi[7:0]);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_v[i][0] = 0; m_v[i][1] = 0; end
    end else if (tlbwi_req) write_model(int'(index % 32));
    else if (tlbwr_req)     write_model(int'(random % 32));
    #1;
    if (rst) begin
      check("rst_i_valid", i_valid, 0);
      check("rst_d_valid", d_valid, 0);
      check("rst_tlbr_done", tlbr_done, 0);
      check("rst_tlbp_done", tlbp_done, 0);
      check("rst_faults", {i_refill, i_invalid, d_refill, d_invalid, d_modified}, 0);
    end else begin
      check("i_valid", i_valid, ireq);
      if (ireq) begin
        check("i_refill", i_refill, ei.refill);
        check("i_invalid", i_invalid, ei.invalid);
        if (!ei.refill && !ei.invalid) begin
          check("i_paddr", i_paddr, ei.paddr);
          check("i_cattr", i_cattr, ei.cattr);
        end
      end
      check("d_valid", d_valid, dreq);
      if (dreq) begin
        check("d_refill", d_refill, ed.refill);
        check("d_invalid", d_invalid, ed.invalid);
        check("d_modified", d_modified, ed.modified);
        if (!ed.refill && !ed.invalid) begin
          check("d_paddr", d_paddr, ed.paddr);
          check("d_cattr", d_cattr, ed.cattr);
        end
      end
      check("tlbr_done", tlbr_done, rreq);
      if (rreq) begin
        check("tlbr_lo0", tlbr_lo0, r_lo0);
        check("tlbr_lo1", tlbr_lo1, r_lo1);
        check("tlbr_hi", tlbr_hi, r_hi);
        check("tlbr_mask", tlbr_mask, r_mask);
      end
      check("tlbp_done", tlbp_done, preq);
      if (preq) check("tlbp_index", tlbp_index, (pidx < 0) ? 32'h8000_0000 : 32'(pidx));
    end
    clear_reqs();
  endtask

  task automatic wr(input int idx, input logic [31:0] hi, input logic [31:0] lo0,
                    input logic [31:0] lo1, input logic [11:0] m, input bit use_rand);
    entryhi = hi; entrylo0 = lo0; entrylo1 = lo1; mask = m;
    if (use_rand) begin tlbwr_req = 1; random = idx; end
    else          begin tlbwi_req = 1; index  = idx; end
    tick();
  endtask

  bit [18:0]  vpool [6] = '{19'h00200, 19'h00201, 19'h00202, 19'h00050, 19'h00003, 19'h60010};
  bit [11:0]  mpool [4] = '{12'h000, 12'h003, 12'h00F, 12'h005};

  function automatic logic [31:0] rand_va();
    logic [31:0] va;
    if ($urandom_range(0, 7) == 0) return {2'b10, 30'($urandom)};
    va = {vpool[$urandom_range(0, 5)], 13'($urandom)};
    return va ^ (32'($urandom_range(0, 15)) << 13);
  endfunction

  initial begin
    clear_reqs();
    resetn = 0; index = 0; random = 0; entryhi = 0; entrylo0 = 0; entrylo1 = 0;
    mask = 0; config_k0 = 3'd3; i_vaddr = 0; d_vaddr = 0;
    tick(); tick();
    resetn = 1;

    // 1: lookups straight out of reset
    i_req = 1; i_vaddr = 32'h0040_0000;
    d_req = 1; d_vaddr = 32'h8000_1234;
    tick();
    check("t1_i_refill", i_refill, 1);
    check("t1_d_paddr", d_paddr, 32'h0000_1234);
    check("t1_d_cattr", d_cattr, 3'd3);

    // Give every entry a known, non-colliding tag before relying on the model.
    for (int i = 0; i < 32; i++) wr(i, {19'h7F000 | 19'(i), 5'b0, 8'hFF}, 0, 0, 0, 0);

    // 2: basic translation and odd-page invalid
    wr(3, 32'h0040_0005, 32'h0000_401E, 32'h0, 12'h000, 0);
    d_req = 1; d_vaddr = 32'h0040_0ABC; tick();
    check("t2_paddr", d_paddr, 32'h0010_0ABC);
    d_req = 1; d_vaddr = 32'h0040_1000; tick();
    check("t2_invalid", d_invalid, 1);

    // 3: store to clean page, then ASID mismatch
    wr(3, 32'h0040_0005, 32'h0000_401A, 32'h0, 12'h000, 0);
    d_req = 1; d_store = 1; d_vaddr = 32'h0040_0000; tick();
    check("t3_modified", d_modified, 1);
    entryhi = 32'h0040_0006;
    d_req = 1; d_vaddr = 32'h0040_0000; tick();
    check("t3_refill", d_refill, 1);

    // 4: masked page, odd half
    wr(3, 32'h0040_0005, 32'h0000_401A, 32'h0000_801A, 12'h003, 0);
    d_req = 1; d_vaddr = 32'h0040_5678; tick();
    check("t4_paddr", d_paddr, 32'h0020_1678);

    // 5: probes: hit, miss, lowest-index priority
    tlbp_req = 1; tick();
    check("t5_hit", tlbp_index, 3);
    entryhi = 32'h1230_0005; tlbp_req = 1; tick();
    check("t5_miss", tlbp_index, 32'h8000_0000);
    wr(7, 32'h00A0_0005, 32'h0000_3006, 32'h0000_3046, 12'h000, 0);
    wr(2, 32'h00A0_0005, 32'h0000_5006, 32'h0000_5046, 12'h000, 1);
    tlbp_req = 1; tick();
    check("t5_prio", tlbp_index, 2);

    // Reset during a pending lookup: valid dropped, V bits cleared, tags kept.
    d_req = 1; d_vaddr = 32'h00A0_0000; resetn = 0; tick();
    resetn = 1;
    d_req = 1; d_vaddr = 32'h00A0_0000; tlbp_req = 1; tick();
    check("rst_invalid", d_invalid, 1);
    check("rst_probe", tlbp_index, 2);

    // 6: tlbwi beats tlbwr; a same-cycle read sees the old contents
    entryhi = 32'h0123_4005; entrylo0 = 32'h0001_2346; entrylo1 = 32'h0004_5679; mask = 12'h00F;
    tlbwi_req = 1; tlbwr_req = 1; index = 4; random = 9; tlbr_req = 1; tick();
    check("t6_old_hi", tlbr_hi, {19'h7F004, 5'b0, 8'hFF});
    index = 9; tlbr_req = 1; tick();
    check("t6_keep9", tlbr_hi, {19'h7F009, 5'b0, 8'hFF});
    index = 4; tlbr_req = 1; tick();
    check("t6_new_hi", tlbr_hi, 32'h0123_4005);
    check("t6_new_mask", tlbr_mask, 12'h00F);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      resetn    = ($urandom_range(0, 149) != 0);
      entryhi   = {vpool[$urandom_range(0, 5)], 5'($urandom), 8'($urandom_range(0, 3))};
      entrylo0  = $urandom;
      entrylo1  = $urandom;
      mask      = mpool[$urandom_range(0, 3)];
      config_k0 = 3'($urandom);
      index     = $urandom;
      random    = $urandom;
      tlbwi_req = ($urandom_range(0, 3) == 0);
      tlbwr_req = ($urandom_range(0, 7) == 0);
      tlbr_req  = 1'($urandom);
      tlbp_req  = 1'($urandom);
      i_req     = ($urandom_range(0, 3) != 0);
      i_vaddr   = rand_va();
      d_req     = ($urandom_range(0, 3) != 0);
      d_vaddr   = rand_va();
      d_store   = 1'($urandom);
      tick();
    end
    resetn = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
